// File: rtl/uart_rx_ctrl_pkg.sv
// Shared UART definitions: FSM state encodings and default frame parameters,
// also used by the TX controller.
package uart_rx_ctrl_pkg;

    // Frame FSM state encodings (kept as plain constants for legacy decoders)
    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] START = 2'b01;
    localparam logic [1:0] DATA  = 2'b10;
    localparam logic [1:0] STOP  = 2'b11;

    // Default frame format: 8 data bits, 1 stop bit, 16x oversampling
    localparam int unsigned DEF_DBIT    = 8;
    localparam int unsigned DEF_SB_TICK = 16;
    localparam int unsigned DEF_OVS     = 16;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous single-bit inputs. Resets to 1 so an
// idle-high line does not look like activity while coming out of reset.
module sync_2ff (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // Shift the async input through two flops
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: synchronises rx, runs the start/data/stop FSM on the
// oversampling tick, assembles the byte LSB-first and reports it with a
// one-cycle done pulse plus a framing-error flag.
module uart_rx_ctrl
    import uart_rx_ctrl_pkg::*;
#(
    parameter int unsigned DBIT    = DEF_DBIT,
    parameter int unsigned SB_TICK = DEF_SB_TICK,
    parameter int unsigned OVS     = DEF_OVS
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            rx,
    input  logic            s_tick,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            frame_err,
    output logic            busy
);

    localparam int unsigned SMAX = (OVS > SB_TICK) ? OVS : SB_TICK;
    localparam int unsigned SW   = $clog2(SMAX);
    localparam int unsigned NW   = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [SW-1:0] S_MID       = SW'(OVS / 2 - 1);
    localparam logic [SW-1:0] S_BIT_LAST  = SW'(OVS - 1);
    localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 1);
    localparam logic [SW-1:0] S_ONE       = SW'(1);
    localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);
    localparam logic [NW-1:0] N_ONE       = NW'(1);

    logic            rx_s;
    logic [1:0]      state_q, state_d;
    logic [SW-1:0]   s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic [DBIT-1:0] dout_q, dout_d;
    logic            done_q, done_d;
    logic            ferr_q, ferr_d;

    sync_2ff u_rx_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (rx),
        .q       (rx_s)
    );

    // Frame FSM next-state, counters, shift register and completion outputs
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        dout_d  = dout_q;
        ferr_d  = ferr_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                // Falling edge detection is not gated by s_tick
                if (!rx_s) begin
                    state_d = START;
                    s_d     = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_q == S_MID) begin
                        s_d = '0;
                        if (!rx_s) begin
                            state_d = DATA;
                            n_d     = '0;
                        end else begin
                            // Start bit did not survive to mid-bit: a glitch
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + S_ONE;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_q == S_BIT_LAST) begin
                        s_d = '0;
                        b_d = {rx_s, b_q[DBIT-1:1]};
                        if (n_q == N_LAST) begin
                            state_d = STOP;
                            n_d     = '0;
                        end else begin
                            n_d = n_q + N_ONE;
                        end
                    end else begin
                        s_d = s_q + S_ONE;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s_q == S_STOP_LAST) begin
                        state_d = IDLE;
                        s_d     = '0;
                        done_d  = 1'b1;
                        dout_d  = b_q;
                        ferr_d  = ~rx_s;
                    end else begin
                        s_d = s_q + S_ONE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                s_d     = '0;
                n_d     = '0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
        end
    end

    assign dout         = dout_q;
    assign rx_done_tick = done_q;
    assign frame_err    = ferr_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: s_tick every 4 clk, one bit = 64 clk.
// Expected bytes are queued when a frame is sent and checked on each pulse.
module tb_uart_rx_ctrl;

    localparam int BIT_CLK = 64;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       rx;
    logic       s_tick;
    logic [7:0] dout;
    logic       rx_done_tick;
    logic       frame_err;
    logic       busy;

    int         n_cmp = 0;
    int         n_err = 0;
    int         done_cnt = 0;
    int         tick_cnt = 0;
    int         last_ticks = 0;
    longint     cyc = 0;
    longint     t_done_prev = 0;
    longint     t_done_last = 0;
    logic       done_prev = 1'b0;
    logic [8:0] sb_q[$];

    uart_rx_ctrl dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .rx           (rx),
        .s_tick       (s_tick),
        .dout         (dout),
        .rx_done_tick (rx_done_tick),
        .frame_err    (frame_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Data bits LSB-first then the stop bit; a bad stop is held low only past
    // its sample point so the line is high again before the next frame.
    task automatic send_rest(input logic [7:0] data, input logic stop_ok);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            wait_clk(BIT_CLK);
        end
        if (stop_ok) begin
            rx = 1'b1;
            wait_clk(BIT_CLK);
        end else begin
            rx = 1'b0;
            wait_clk(40);
            rx = 1'b1;
            wait_clk(BIT_CLK - 40);
        end
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop_ok);
        sb_q.push_back({~stop_ok, data});
        rx = 1'b0;
        wait_clk(BIT_CLK);
        send_rest(data, stop_ok);
    endtask

    // Free-running tick: high for one clk out of every four
    initial begin
        s_tick = 1'b0;
        forever begin
            repeat (3) @(posedge clk);
            #1 s_tick = 1'b1;
            @(posedge clk);
            #1 s_tick = 1'b0;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Output monitor: scoreboard pops, pulse width, ticks spent busy per frame
    initial begin
        logic [8:0] exp_e;
        forever begin
            @(negedge clk);
            if (done_prev) check("pulse_width", {31'b0, rx_done_tick}, 32'd0);
            if (rx_done_tick) begin
                done_cnt++;
                t_done_prev = t_done_last;
                t_done_last = cyc;
                last_ticks  = tick_cnt;
                if (sb_q.size() == 0) begin
                    check("unexpected_pulse", sb_q.size(), 32'd1);
                end else begin
                    exp_e = sb_q.pop_front();
                    check("dout", {24'b0, dout}, {24'b0, exp_e[7:0]});
                    check("frame_err", {31'b0, frame_err}, {31'b0, exp_e[8]});
                end
            end
            if (!busy) tick_cnt = 0;
            else if (s_tick) tick_cnt++;
            done_prev = rx_done_tick;
        end
    end

    initial begin
        int c0;
        reset_n = 1'b0;
        rx      = 1'b1;
        wait_clk(5);
        check("rst_dout", {24'b0, dout}, 32'd0);
        check("rst_done", {31'b0, rx_done_tick}, 32'd0);
        check("rst_ferr", {31'b0, frame_err}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        reset_n = 1'b1;
        wait_clk(20);

        // 0x55: busy shortly after the start edge, exactly one pulse
        c0 = done_cnt;
        sb_q.push_back({1'b0, 8'h55});
        rx = 1'b0;
        wait_clk(8);
        check("busy_in_frame", {31'b0, busy}, 32'd1);
        wait_clk(BIT_CLK - 8);
        send_rest(8'h55, 1'b1);
        wait_clk(40);
        check("pulses_55", done_cnt, c0 + 1);
        check("idle_after_55", {31'b0, busy}, 32'd0);

        // 0xA3: LSB-first order and start-detect-to-pulse latency in ticks
        send_frame(8'hA3, 1'b1);
        wait_clk(40);
        check("latency_ticks", last_ticks, 32'd152);

        // Start glitch: low for 3 ticks, FSM gives up at mid start bit
        c0 = done_cnt;
        rx = 1'b0;
        wait_clk(8);
        check("glitch_busy", {31'b0, busy}, 32'd1);
        wait_clk(4);
        rx = 1'b1;
        wait_clk(8);
        check("glitch_still_start", {31'b0, busy}, 32'd1);
        wait_clk(40);
        check("glitch_idle", {31'b0, busy}, 32'd0);
        wait_clk(200);
        check("glitch_no_pulse", done_cnt, c0);
        check("glitch_dout_hold", {24'b0, dout}, 32'hA3);

        // Bad stop bit, then a good frame clears the flag
        send_frame(8'h3C, 1'b0);
        wait_clk(100);
        check("ferr_held", {31'b0, frame_err}, 32'd1);
        send_frame(8'h81, 1'b1);
        wait_clk(40);

        // Reset during data bit 4: outputs drop immediately, no pulse
        c0 = done_cnt;
        rx = 1'b0;
        wait_clk(BIT_CLK);
        for (int i = 0; i < 4; i++) begin
            rx = i[0];
            wait_clk(BIT_CLK);
        end
        rx = 1'b1;
        wait_clk(32);
        reset_n = 1'b0;
        #1;
        check("midrst_dout", {24'b0, dout}, 32'd0);
        check("midrst_ferr", {31'b0, frame_err}, 32'd0);
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_done", {31'b0, rx_done_tick}, 32'd0);
        wait_clk(3);
        reset_n = 1'b1;
        wait_clk(100);
        check("midrst_no_pulse", done_cnt, c0);
        send_frame(8'hC7, 1'b1);
        wait_clk(40);

        // Back-to-back with no idle gap
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        for (int i = 0; i < 200 && sb_q.size() != 0; i++) wait_clk(1);
        check("b2b_spacing_clk", 32'(t_done_last - t_done_prev), 32'd640);
        check("sb_drained", sb_q.size(), 32'd0);
        check("pulse_total", done_cnt, 32'd7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
